// File: rtl/multi_cycle_ctrl_pkg.sv
// rtl/multi_cycle_ctrl_pkg.sv - shared state, opcode and ALUOp encodings for the multi-cycle controller
package multi_cycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_ALU_WB   = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALUOP_NONE  = 3'b000;
  localparam logic [2:0] ALUOP_BR    = 3'b001;
  localparam logic [2:0] ALUOP_R     = 3'b010;
  localparam logic [2:0] ALUOP_ADD   = 3'b100;
  localparam logic [2:0] ALUOP_SLTIU = 3'b101;
  localparam logic [2:0] ALUOP_ORI   = 3'b110;
  localparam logic [2:0] ALUOP_LUI   = 3'b111;

  // Unsupported opcodes map back to FETCH; the caller flags them separately.
  function automatic state_t decode_next(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW:                      decode_next = S_MEM_ADDR;
      OP_RTYPE:                          decode_next = S_R_EXEC;
      OP_BEQ, OP_BNE:                    decode_next = S_BRANCH;
      OP_J:                              decode_next = S_JUMP;
      OP_ADDI, OP_SLTIU, OP_ORI, OP_LUI: decode_next = S_I_EXEC;
      default:                           decode_next = S_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/multi_cycle_ctrl.sv
// rtl/multi_cycle_ctrl.sv - multi-cycle datapath controller with retire counter and illegal-opcode flag
module multi_cycle_ctrl
  import multi_cycle_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [5:0]  op_i,
  input  logic        zero_i,
  input  logic        mem_ready_i,
  output logic        pc_we_o,
  output logic        ir_we_o,
  output logic        iord_o,
  output logic        mem_rd_o,
  output logic        mem_wr_o,
  output logic        reg_we_o,
  output logic        reg_dst_o,
  output logic        mem_to_reg_o,
  output logic        alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic [2:0]  ALUOp_o,
  output logic [1:0]  pc_src_o,
  output logic [3:0]  state_o,
  output logic [31:0] instr_cnt_o,
  output logic        illegal_o
);

  state_t      r_state;
  logic [31:0] r_instr_cnt;
  logic        r_illegal;

  state_t      w_next;
  logic        w_retire;
  logic        w_bad_op;
  logic        w_pc_we;
  logic        w_mem_rd;

  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    w_bad_op = 1'b0;
    case (r_state)
      S_FETCH:    if (mem_ready_i) w_next = S_DECODE;
      S_DECODE: begin
        w_next   = decode_next(op_i);
        w_bad_op = (decode_next(op_i) == S_FETCH);
      end
      S_MEM_ADDR: w_next = (op_i == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready_i) w_next = S_MEM_WB;
      S_MEM_WR: begin
        if (mem_ready_i) begin
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end
      end
      S_R_EXEC, S_I_EXEC: w_next = S_ALU_WB;
      S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      default:    w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= S_FETCH;
      r_instr_cnt <= 32'd0;
      r_illegal   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_instr_cnt <= r_instr_cnt + 32'd1;
      if (w_bad_op) r_illegal   <= 1'b1;
    end
  end

  always_comb begin
    w_pc_we      = 1'b0;
    ir_we_o      = 1'b0;
    iord_o       = 1'b0;
    w_mem_rd     = 1'b0;
    mem_wr_o     = 1'b0;
    reg_we_o     = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'b00;
    ALUOp_o      = ALUOP_NONE;
    pc_src_o     = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_mem_rd    = 1'b1;
        alu_src_b_o = 2'b01;
        ALUOp_o     = ALUOP_ADD;
        ir_we_o     = mem_ready_i;
        w_pc_we     = mem_ready_i;
      end
      S_DECODE: begin
        alu_src_b_o = 2'b11;
        ALUOp_o     = ALUOP_ADD;
      end
      S_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        ALUOp_o     = ALUOP_ADD;
      end
      S_MEM_RD: begin
        w_mem_rd = 1'b1;
        iord_o   = 1'b1;
      end
      S_MEM_WB: begin
        reg_we_o     = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      S_MEM_WR: begin
        mem_wr_o = 1'b1;
        iord_o   = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a_o = 1'b1;
        ALUOp_o     = ALUOP_R;
      end
      S_I_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        case (op_i)
          OP_SLTIU: ALUOp_o = ALUOP_SLTIU;
          OP_ORI:   ALUOp_o = ALUOP_ORI;
          OP_LUI:   ALUOp_o = ALUOP_LUI;
          default:  ALUOp_o = ALUOP_ADD;
        endcase
      end
      S_ALU_WB: begin
        reg_we_o  = 1'b1;
        reg_dst_o = (op_i == OP_RTYPE);
      end
      S_BRANCH: begin
        alu_src_a_o = 1'b1;
        ALUOp_o     = ALUOP_BR;
        pc_src_o    = 2'b01;
        w_pc_we     = (op_i == OP_BNE) ? ~zero_i : zero_i;
      end
      S_JUMP: begin
        pc_src_o = 2'b10;
        w_pc_we  = 1'b1;
      end
      default: ;
    endcase
  end

  // Memory read and PC write are gated straight from reset so they drop without a clock.
  assign mem_rd_o    = w_mem_rd & rst_i;
  assign pc_we_o     = w_pc_we & rst_i;
  assign state_o     = r_state;
  assign instr_cnt_o = r_instr_cnt;
  assign illegal_o   = r_illegal;

endmodule
